// File: rtl/axis_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_fifo_reader                                                |
// | Purpose  : Pops samples from a ring FIFO with a 1-cycle read latency and   |
// |            presents them as an AXI-Stream master. A 2-entry output buffer  |
// |            absorbs the read latency so no beat is lost or duplicated under |
// |            any tready pattern. Frames the stream with tlast every          |
// |            FRAME_LEN beats and counts underrun cycles (saturating).        |
// | Ports    : axis_aclk / axis_aresetn  clock, async active-low reset         |
// |            enable                    run request                           |
// |            fifo_rd_en / fifo_rd_data / fifo_empty   FIFO read port         |
// |            m_axis_tdata/tvalid/tready/tlast          AXI-Stream master     |
// |            busy                      state machine not idle                |
// |            underrun_count            saturating underrun cycle count       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module axis_fifo_reader #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             enable,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] underrun_count
);

  // A one-beat frame still needs a 1-bit counter (it simply stays at 0).
  localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  head_data;   // buffer entry presented on the bus
  logic [WIDTH-1:0]  tail_data;   // second entry, valid only when occ = 2
  logic [1:0]        occ;         // buffered entries, 0..2
  logic              infl;        // a pop was issued last cycle; data arrives now
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  under_cnt;

  logic              pop_out;
  logic [2:0]        occ_proj;

  // Handshake completing this cycle.
  assign pop_out  = (occ != 2'd0) && m_axis_tready;

  // Entries the buffer will hold after this edge, counting the in-flight word.
  // pop_out implies occ >= 1, so this never goes negative.
  assign occ_proj = {1'b0, occ} + {2'b0, infl} - {2'b0, pop_out};

  // A new pop is only allowed when the buffer is guaranteed to have room for
  // its data next cycle. Gating with enable lets a falling enable win over a
  // FIFO that becomes non-empty in the same cycle: draining takes priority.
  assign fifo_rd_en = (state == ST_RUN) && enable && !fifo_empty && (occ_proj < 3'd2);

  assign m_axis_tdata   = head_data;
  assign m_axis_tvalid  = (occ != 2'd0);
  assign m_axis_tlast   = (occ != 2'd0) && (beat_cnt == LAST_BEAT);
  assign busy           = (state != ST_IDLE);
  assign underrun_count = under_cnt;

  // --------------------------------------------------------------------------
  // Output buffer: capture of the in-flight word and the output pop can both
  // happen in one cycle. The head only changes on a pop or when the buffer is
  // empty, which keeps tdata stable while a beat is stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      head_data <= '0;
      tail_data <= '0;
      occ       <= 2'd0;
      infl      <= 1'b0;
    end else begin
      infl <= fifo_rd_en;
      case ({infl, pop_out})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= fifo_rd_data;
          end else begin
            tail_data <= fifo_rd_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the arriving word replaces whichever entry
          // moves forward.
          if (occ == 2'd1) begin
            head_data <= fifo_rd_data;
          end else begin
            head_data <= tail_data;
            tail_data <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame beat counter. It keeps its value across IDLE so frames span gaps in
  // enable; only reset clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      beat_cnt <= '0;
    end else if (pop_out) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Underrun: downstream is ready, we are running, but nothing is buffered,
  // nothing is on its way and the FIFO has nothing to give.
  // --------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      under_cnt <= '0;
    end else if ((state == ST_RUN) && (occ == 2'd0) && !infl && fifo_empty &&
                 m_axis_tready && (under_cnt != CNT_MAX)) begin
      under_cnt <= under_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Run control. DRAIN lets buffered and in-flight data leave before going
  // idle; a re-enable during DRAIN returns straight to RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_RUN;
          end else if ((occ == 2'd0) && !infl) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_fifo_reader                                             |
// | Purpose  : Self-checking bench for axis_fifo_reader. A behavioural FIFO    |
// |            with 1-cycle read latency feeds the DUT; the output stream is   |
// |            compared against the FIFO contents in order, tlast against the  |
// |            beat index, and underrun_count against a cycle-level rule model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axis_fifo_reader;

  localparam int FL    = 256;
  localparam int CNT_W = 4;
  localparam int UMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fifo_rd_en;
  logic [15:0]      fifo_rd_data = '0;
  logic             fifo_empty;
  logic [15:0]      tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             busy;
  logic [CNT_W-1:0] underrun_count;

  always #5 clk = ~clk;

  axis_fifo_reader #(
    .WIDTH     (16),
    .FRAME_LEN (FL),
    .CNT_W     (CNT_W)
  ) dut (
    .axis_aclk      (clk),
    .axis_aresetn   (rst_n),
    .enable         (enable),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_empty     (fifo_empty),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .busy           (busy),
    .underrun_count (underrun_count)
  );

  // Behavioural source FIFO: data appears on fifo_rd_data the cycle after a pop.
  logic [15:0] mem [0:4095];
  int          wr_ptr   = 0;
  int          rd_ptr   = 0;
  logic [15:0] next_val = 16'h0055;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= mem[rd_ptr[11:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Reference model state
  int          tests = 0;
  int          fails = 0;
  int          exp_ptr = 0;          // next FIFO entry the stream must deliver
  int          beats_total = 0;
  int          beats_since_rst = 0;
  int          last_count = 0;
  int          exp_under = 0;
  bit          run_now = 1'b0;       // model: state is RUN this cycle
  bit          rd_prev = 1'b0;       // a pop was issued last cycle
  bit          stall_prev = 1'b0;
  logic [15:0] data_prev = '0;
  logic        last_prev = 1'b0;
  logic        smp_rd_en, smp_tvalid, smp_busy;

  typedef struct {
    int preload;
    int pct;        // tready probability in percent
    int cycles;
    int exp_beats;
    int exp_pops;
    bit exp_valid;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[11:0]] = next_val;
      next_val = next_val + 16'd1;
      wr_ptr++;
    end
  endtask

  task automatic model_reset();
    exp_ptr         = rd_ptr;
    beats_since_rst = 0;
    exp_under       = 0;
    run_now         = 1'b0;
    rd_prev         = 1'b0;
    stall_prev      = 1'b0;
  endtask

  // Runs at the falling edge: checks this cycle's outputs, then advances the model.
  task automatic monitor();
    check("rd_en_on_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
    if (stall_prev) begin
      check("hold_valid", {31'd0, tvalid}, 32'd1);
      check("hold_data", {16'd0, tdata}, {16'd0, data_prev});
      check("hold_last", {31'd0, tlast}, {31'd0, last_prev});
    end
    if (tvalid) check("tlast", {31'd0, tlast}, {31'd0, (beats_since_rst % FL) == FL - 1});
    else        check("tlast_idle", {31'd0, tlast}, 32'd0);
    check("underrun", {28'd0, underrun_count}, exp_under);
    if (tvalid && tready) begin
      check("beat_available", {31'd0, exp_ptr < wr_ptr}, 32'd1);
      check("tdata", {16'd0, tdata}, {16'd0, mem[exp_ptr[11:0]]});
      if (tlast) last_count++;
      exp_ptr++;
      beats_total++;
      beats_since_rst++;
    end
    if (run_now && !tvalid && !rd_prev && fifo_empty && tready && exp_under < UMAX)
      exp_under++;
    run_now    = enable;
    rd_prev    = fifo_rd_en;
    stall_prev = tvalid && !tready;
    data_prev  = tdata;
    last_prev  = tlast;
    smp_rd_en  = fifo_rd_en;
    smp_tvalid = tvalid;
    smp_busy   = busy;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_ready(input int pct);
    return (int'($urandom_range(99)) < pct);
  endfunction

  initial begin
    int  b0, b1, p0, nl0;
    bit  found;

    vecs[0] = '{preload: 512, pct: 100, cycles: 540,  exp_beats: 512, exp_pops: 512, exp_valid: 1'b0};
    vecs[1] = '{preload: 512, pct: 50,  cycles: 1500, exp_beats: 512, exp_pops: 512, exp_valid: 1'b0};
    vecs[2] = '{preload: 40,  pct: 75,  cycles: 200,  exp_beats: 40,  exp_pops: 40,  exp_valid: 1'b0};
    vecs[3] = '{preload: 5,   pct: 0,   cycles: 20,   exp_beats: 0,   exp_pops: 2,   exp_valid: 1'b1};

    rst_n  = 1'b0;
    enable = 1'b0;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {28'd0, underrun_count}, 32'd0);
    check("rst_tdata", {16'd0, tdata}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Table-driven runs
    for (int r = 0; r < 4; r++) begin
      b0 = beats_total;
      p0 = rd_ptr;
      push(vecs[r].preload);
      enable = 1'b1;
      found  = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        tready = rnd_ready(vecs[r].pct);
        cycle();
        if (smp_rd_en) found = 1'b1;
      end
      check("first_pop_seen", {31'd0, found}, 32'd1);
      tready = rnd_ready(vecs[r].pct);
      cycle();
      check("valid_latency_1", {31'd0, smp_tvalid}, 32'd0);
      tready = rnd_ready(vecs[r].pct);
      cycle();
      check("valid_latency_2", {31'd0, smp_tvalid}, 32'd1);
      for (int n = 0; n < vecs[r].cycles; n++) begin
        tready = rnd_ready(vecs[r].pct);
        cycle();
      end
      check("row_beats", beats_total - b0, vecs[r].exp_beats);
      check("row_pops", rd_ptr - p0, vecs[r].exp_pops);
      check("row_valid", {31'd0, smp_tvalid}, {31'd0, vecs[r].exp_valid});
      check("row_busy", {31'd0, smp_busy}, 32'd1);
    end

    // Release the stalled stream: 2 buffered + 3 still in the FIFO
    b0 = beats_total;
    tready = 1'b1;
    repeat (20) cycle();
    check("release_beats", beats_total - b0, 32'd5);

    // Drop enable after beat 100 with two entries buffered
    b0 = beats_total;
    push(300);
    enable = 1'b1;
    tready = 1'b1;
    for (int k = 0; k < 400 && (beats_total - b0) < 100; k++) cycle();
    check("reach_beat_100", beats_total - b0, 32'd100);
    tready = 1'b0;
    cycle();
    cycle();
    enable = 1'b0;
    p0 = rd_ptr;
    b1 = beats_total;
    cycle();
    tready = 1'b1;
    repeat (10) cycle();
    check("drain_beats", beats_total - b1, 32'd2);
    check("drain_no_pop", rd_ptr - p0, 32'd0);
    check("drain_busy", {31'd0, smp_busy}, 32'd0);
    check("drain_valid", {31'd0, smp_tvalid}, 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 400 && exp_ptr < wr_ptr; k++) cycle();
    check("resume_all_beats", beats_total - b0, 32'd300);

    // Reset mid-stream with the buffer full
    push(300);
    tready = 1'b1;
    repeat (10) cycle();
    tready = 1'b0;
    cycle();
    cycle();
    check("pre_rst_valid", {31'd0, smp_tvalid}, 32'd1);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("async_rst_tlast", {31'd0, tlast}, 32'd0);
    check("async_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_underrun", {28'd0, underrun_count}, 32'd0);
    model_reset();
    cycle();
    cycle();
    rst_n  = 1'b1;
    enable = 1'b1;
    tready = 1'b1;
    nl0 = last_count;
    for (int k = 0; k < 400 && exp_ptr < wr_ptr; k++) cycle();
    check("post_rst_drained", {31'd0, exp_ptr == wr_ptr}, 32'd1);
    check("post_rst_tlast_cnt", last_count - nl0, 32'd1);

    // Underrun saturation from a clean reset
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    model_reset();
    cycle();
    rst_n  = 1'b1;
    enable = 1'b1;
    tready = 1'b1;
    repeat (20) cycle();
    check("underrun_saturated", {28'd0, underrun_count}, UMAX);
    check("sat_busy", {31'd0, smp_busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
